// File: rtl/spike_event_encoder.sv
// rtl/spike_event_encoder.sv - threshold spike detector with refractory gating and timestamp FIFO
// Optional spike-rate window enabled by defining SPIKE_RATE_EN.
module spike_event_encoder #(
    parameter logic signed [20:0] V_TH         = 21'sd15360,
    parameter int                 REFR_STEPS   = 2,
    parameter int                 FIFO_DEPTH   = 8,
    parameter int                 TS_W         = 16,
    parameter int                 WINDOW_STEPS = 100
) (
    input  logic                          clk,
    input  logic                          set,
    input  logic signed [20:0]            v_in,
    input  logic                          v_valid,
    output logic                          spike,
    output logic [15:0]                   spike_count,
    output logic                          ev_valid,
    output logic [TS_W-1:0]               ev_data,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    rate,
    output logic                          rate_valid
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0] step_cnt;
    logic [7:0]      refr_cnt;
    logic            armed;
    logic            fire;

    logic [TS_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            full;
    logic            pop;
    logic            push;

    assign fire = v_valid && armed && (v_in >= V_TH) && (refr_cnt == 8'd0);

    assign full = (level == LW'(FIFO_DEPTH));
    assign pop  = (level != '0) && ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push = fire && (!full || pop);

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            step_cnt    <= '0;
            refr_cnt    <= '0;
            armed       <= 1'b1;
            spike       <= 1'b0;
            spike_count <= '0;
        end else begin
            spike <= fire;
            if (v_valid) begin
                step_cnt <= step_cnt + 1'b1;
                if (v_in < V_TH)
                    armed <= 1'b1;
                else if (fire)
                    armed <= 1'b0;
                if (fire)
                    refr_cnt <= 8'(REFR_STEPS);
                else if (refr_cnt != 8'd0)
                    refr_cnt <= refr_cnt - 8'd1;
            end
            if (fire && spike_count != 16'hFFFF)
                spike_count <= spike_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= step_cnt;
    end

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (fire && !push)
                overflow <= 1'b1;
        end
    end

    assign ev_valid   = (level != '0);
    assign ev_data    = ev_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

`ifdef SPIKE_RATE_EN
    localparam logic [15:0] WIN_LAST = 16'(WINDOW_STEPS - 1);

    logic [15:0] win_cnt;
    logic [7:0]  win_spk;

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            win_cnt    <= '0;
            win_spk    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (v_valid) begin
                if (win_cnt == WIN_LAST) begin
                    // A fire on the closing step counts here and never seeds the next window.
                    win_cnt    <= '0;
                    win_spk    <= '0;
                    rate       <= (fire && win_spk != 8'hFF) ? win_spk + 8'd1 : win_spk;
                    rate_valid <= 1'b1;
                end else begin
                    win_cnt <= win_cnt + 16'd1;
                    if (fire && win_spk != 8'hFF)
                        win_spk <= win_spk + 8'd1;
                end
            end
        end
    end
`else
    assign rate       = '0;
    assign rate_valid = 1'b0;
`endif

endmodule
